// File: rtl/timer_counter.sv
// timer_counter -- bus-mapped down-counting timer with interrupt.
//
// Register map (addr = bus address bits [3:2]):
//   0 CTRL   : bit0 EN, bits[2:1] MODE (01 auto-reload, otherwise one-shot),
//              bit3 IM (interrupt mask); bits[31:4] read as 0
//   1 PRESET : reload value, read/write
//   2 COUNT  : current count, read-only
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk   in   1  system clock, rising-edge
//   reset in   1  synchronous, active-high reset
//   addr  in   2  register select
//   we    in   1  write enable, sampled on the rising edge
//   din   in  32  write data
//   dout  out 32  read data, combinational from addr
//   irq   out  1  interrupt request = IM & IRQF (two flops ANDed)
//
// Timing: from the edge that writes EN=1, IRQF rises N+2 edges later
// (N = max(PRESET,1)); in auto-reload the period is N+3 cycles.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irqf_q, irqf_d;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;
  logic        en_eff;

  assign wr_ctrl     = we && (addr == 2'd0);
  assign wr_preset   = we && (addr == 2'd1);
  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  // While counting, a same-cycle CTRL write decides whether we keep going,
  // so clearing EN stops the count at this very edge.
  assign en_eff      = wr_ctrl ? din[0] : en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irqf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irqf_q   <= irqf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irqf_d   = irqf_q;

    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Terminal count: 0 and 1 both land here, so they time the same.
          count_d = 32'd0;
          irqf_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        if (auto_reload) irqf_d    = 1'b0;
        else             ctrl_d[0] = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Bus writes come last so they win over the FSM, including on IRQF.
    if (wr_ctrl) begin
      ctrl_d = din[3:0];
      irqf_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = din;
      irqf_d   = 1'b0;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & irqf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter: table-driven register vectors, directed
// timing sequences, and randomized traffic against a timeline model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is described by its age (edges since the run
  // was started from idle) and the preset latched at load time.
  logic        m_en, m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_pre, m_cnt;
  logic        m_irqf, m_run;
  int          m_age;
  longint      m_lp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic   wc, wp, ee, setf, clrf, clr_en;
    longint n, rem;
    if (r) begin
      m_en = 0; m_im = 0; m_mode = 0; m_pre = 0; m_cnt = 0;
      m_irqf = 0; m_run = 0; m_age = 0; m_lp = 0;
      return;
    end
    wc = w && (a == 2'd0);
    wp = w && (a == 2'd1);
    ee = wc ? d[0] : m_en;
    setf = 0; clrf = 0; clr_en = 0;
    if (!m_run) begin
      if (m_en) begin m_run = 1; m_age = 0; end
    end else begin
      m_age++;
      n = (m_lp > 1) ? m_lp : 1;
      if (m_age == 1) begin
        m_lp  = longint'(m_pre);
        m_cnt = m_pre;
      end else if (m_age <= n + 1) begin
        if (!ee) m_run = 0;
        else begin
          rem   = m_lp - (m_age - 1);
          m_cnt = (rem > 0) ? 32'(rem) : 32'd0;
          if (m_age == n + 1) setf = 1;
        end
      end else begin
        m_run = 0;
        if (m_mode == 2'b01) clrf = 1;
        else                 clr_en = 1;
      end
    end
    if (wc) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
    else if (clr_en) m_en = 0;
    if (wp) m_pre = d;
    if (wc || wp) m_irqf = 0;
    else if (setf) m_irqf = 1;
    else if (clrf) m_irqf = 0;
  endtask

  // One clock: drive inputs, take the edge, update the model, then compare.
  task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                     input logic [31:0] d);
    reset = r; we = w; addr = a; din = d;
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
    chk("model_dout", dout, m_dout(a));
    chk("model_irq", {31'd0, irq}, {31'd0, m_im & m_irqf});
  endtask

  // Combinational read between edges.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    we = 0; reset = 0; addr = a;
    #1;
    chk(nm, dout, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, w;
    logic [1:0]  a;
    logic [31:0] d;

    reset = 1; we = 0; addr = 0; din = 0;

    // Register access vectors
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h123,      32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 32'hFFFF,     32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'hFFFFFFF6, 32'h6,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 32'h77,       32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rst, vecs[i].w, vecs[i].a, vecs[i].d);
      chk("vec_dout", dout, vecs[i].exp_dout);
      chk("vec_irq", {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // One-shot, PRESET=5, IM set
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 2, 0);
      chk("os_irq", {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 6) chk("os_count", dout, 32'(7 - k));
      if (k >= 7) chk("os_count0", dout, 32'd0);
    end
    rd(0, 32'h8, "os_ctrl");
    cyc(0, 1, 0, 32'h8);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: pulse every 6 cycles
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 3);
    cyc(0, 1, 0, 32'hB);
    for (int k = 1; k <= 25; k++) begin
      cyc(0, 0, 2, 0);
      chk("ar_irq", {31'd0, irq}, (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
      if (k >= 2 && (k - 2) % 6 == 0) chk("ar_reload", dout, 32'd3);
    end

    // Masked one-shot, PRESET=2
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 2);
    cyc(0, 1, 0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 2, 0);
      chk("mask_irq", {31'd0, irq}, 32'd0);
    end
    chk("mask_count", dout, 32'd0);
    rd(0, 32'h0, "mask_ctrl");
    cyc(0, 1, 0, 32'h8);
    chk("mask_irq_im", {31'd0, irq}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("mask_irq_im2", {31'd0, irq}, 32'd0);

    // Pause at COUNT=10 with PRESET=20, then re-enable
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 20);
    cyc(0, 1, 0, 32'h1);
    for (int k = 1; k <= 12; k++) cyc(0, 0, 2, 0);
    chk("pause_pre", dout, 32'd10);
    cyc(0, 1, 0, 32'h0);
    rd(2, 32'd10, "pause_freeze");
    cyc(0, 0, 2, 0);
    cyc(0, 0, 2, 0);
    chk("pause_hold", dout, 32'd10);
    cyc(0, 1, 0, 32'h1);
    cyc(0, 0, 2, 0);
    cyc(0, 0, 2, 0);
    chk("pause_reload", dout, 32'd20);

    // Reset while in INT with irq high, and reset mid-count
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 32'h9);
    for (int k = 1; k <= 3; k++) cyc(0, 0, 2, 0);
    chk("int_irq", {31'd0, irq}, 32'd1);
    cyc(1, 1, 1, 32'h55);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) rd(2'(i), 32'd0, "rst_regs");
    cyc(0, 1, 1, 9);
    cyc(0, 1, 0, 32'h9);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 2, 0);
    cyc(1, 0, 2, 0);
    chk("rst_midcount", dout, 32'd0);

    // Randomized traffic against the model
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 7);
      cyc(r, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have these ports, each named with direction, width and meaning below; clock and reset come first.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 addr  in  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  in  1  bus write enable, sampled at rising edge.
REQ-006 din  in  32  bus write data.
REQ-007 dout  out  32  bus read data.
REQ-008 irq  out  1  interrupt request; drives bit 0 of the processor's 6-bit hardware interrupt bus.

Function
REQ-009 The block SHALL define CTRL as follows: bit0 EN (enable), bits[2:1] MODE (00 one-shot, 01 auto-reload; 10 and 11 behave as 00), bit3 IM (interrupt mask); CTRL[31:4] reads 0.
REQ-010 The block SHALL hold PRESET and COUNT as 32-bit registers; COUNT is read-only, and writes to addr 2 or 3 are ignored.
REQ-011 dout SHALL be combinational from addr: CTRL (zero-extended), PRESET, COUNT, or 0 for addr 3.
REQ-012 When we=1 and addr=0, the block SHALL load din[3:0] into CTRL and clear the irq flag (IRQF).
REQ-013 When we=1 and addr=1, the block SHALL load din into PRESET and clear IRQF.
REQ-014 irq SHALL equal IM AND IRQF.
REQ-015 The FSM SHALL have four states: IDLE, LOAD, CNT, INT.
REQ-016 IDLE: if EN=1, the next state SHALL be LOAD; otherwise it SHALL stay in IDLE, and COUNT SHALL hold.
REQ-017 LOAD: the block SHALL set COUNT to PRESET and make CNT the next state.
REQ-018 CNT, EN=0: the next state SHALL be IDLE and COUNT SHALL hold.
REQ-019 CNT, EN=1, COUNT>1: the block SHALL decrement COUNT by 1 and stay in CNT.
REQ-020 CNT, EN=1, COUNT<=1: the block SHALL set COUNT to 0, set IRQF to 1 and make INT the next state; a PRESET of 0 or 1 therefore gives identical timing.
REQ-021 INT, one-shot mode: the block SHALL clear EN, go to IDLE, and hold IRQF at 1 until software writes CTRL or PRESET.
REQ-022 INT, auto-reload mode: the block SHALL clear IRQF and go to IDLE, so IRQF is high for exactly one cycle; with EN still 1 the cycle repeats.
REQ-023 From the edge that writes EN=1, IRQF SHALL rise N+2 edges later (N = max(PRESET,1)); the auto-reload period SHALL be N+3 cycles.
REQ-024 A bus write SHALL take priority over the FSM's own update of the same register in the same cycle; writing CTRL EN=0 during CNT makes the next state IDLE.
REQ-025 A bus write and an FSM transition that both set or clear IRQF in the same cycle SHALL resolve to cleared (IRQF=0).
REQ-026 A PRESET write during CNT SHALL NOT alter COUNT; it takes effect at the next LOAD.
REQ-027 Decrement SHALL never underflow, and COUNT SHALL never wrap below 0.
REQ-028 irq SHALL be glitch-free registered logic: the AND of two flops only.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL set CTRL=0, PRESET=0, COUNT=0, IRQF=0 and state=IDLE, giving irq=0.
REQ-030 Reset SHALL override simultaneous bus writes and FSM activity, including reset mid-count or in INT.

Verification
REQ-031 The bench SHALL cover reset then read all addresses -> dout=0 for addr 0..3, and irq=0.
REQ-032 The bench SHALL cover PRESET=5, then CTRL=0x9 (EN, one-shot, IM) -> COUNT visits 5,4,3,2,1,0; irq rises 7 edges after the CTRL write and stays high; CTRL reads 0x8; a later CTRL write of 0x8 drops irq.
REQ-033 The bench SHALL cover PRESET=3 and CTRL=0xB (auto-reload) -> irq 1-cycle pulses every 6 cycles, with COUNT reloaded to 3 each period.
REQ-034 The bench SHALL cover IM=0, one-shot, PRESET=2 -> irq stays 0, COUNT reaches 0, and the state returns to IDLE; a later CTRL write of 0x8 with no EN leaves irq=0 because IRQF was cleared.
REQ-035 The bench SHALL cover writing CTRL EN=0 while COUNT=10 (PRESET=20) -> COUNT freezes at 9 or 10 per edge timing; re-enabling reloads 20.
REQ-036 The bench SHALL cover reset asserted in INT state with irq=1 -> irq=0 and all registers 0 after one edge.
